fb_draw_ctrl: RTL and testbench

Sequences all writes into the 256-byte CHIP-8 framebuffer (64x32 pixels, 1 bpp, byte address = row*8 + col/8, MSB = leftmost pixel).
Executes CLS and DRW commands from the CPU: fetches sprite bytes from main memory, then XOR-writes them into the framebuffer using read-modify-write.
Shares the single framebuffer port with the VGA scanout reader. Scanout always has priority; this block stalls and retries.

---
 rtl/chip8_pkg.sv | 30 +++
 rtl/sprite_align.sv | 36 +++
 rtl/fb_draw_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_fb_draw_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared constants and encodings for the CHIP-8 framebuffer draw path.
// Framebuffer is 64x32 at 1 bpp, byte address = row*8 + col/8, MSB = leftmost pixel.
package chip8_pkg;

    localparam int unsigned FB_COLS          = 64;
    localparam int unsigned FB_ROWS          = 32;
    localparam int unsigned FB_BYTES_PER_ROW = 8;
    localparam int unsigned FB_BYTES         = 256;

    typedef enum logic {
        OP_CLS = 1'b0,
        OP_DRW = 1'b1
    } cmd_op_e;

    typedef enum logic [3:0] {
        StIdle,
        StClsWr,
        StFetch,
        StSprCap,
        StLRd,
        StLCap,
        StLWr,
        StRRd,
        StRCap,
        StRWr,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/sprite_align.sv
// Splits one sprite byte across the two framebuffer bytes it can touch at column x.
// Purely combinational; the right byte may wrap to column byte 0 of the same row.
module sprite_align
    import chip8_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic [7:0] s,
    input  logic [5:0] x,
    input  logic [4:0] yr,
    output logic [7:0] left_pat,
    output logic [7:0] right_pat,
    output logic [7:0] left_addr,
    output logic [7:0] right_addr,
    output logic       right_valid
);

    localparam logic [2:0] LastCol = 3'(FB_BYTES_PER_ROW - 1);

    logic [2:0]  sh;
    logic [2:0]  col;
    logic [15:0] spread;

    always_comb begin
        sh          = x[2:0];
        col         = x[5:3];
        // Upper byte is s >> sh, lower byte is the spill (s << (8 - sh)).
        spread      = {s, 8'h00} >> sh;
        left_pat    = spread[15:8];
        right_pat   = spread[7:0];
        left_addr   = {yr, col};
        right_addr  = {yr, col + 3'd1};
        right_valid = (sh != 3'd0) && (WRAP || (col != LastCol));
    end

endmodule

// File: rtl/fb_draw_ctrl.sv
// CLS/DRW sequencer for the CHIP-8 framebuffer; XOR-draws sprites by read-modify-write.
// The framebuffer port is shared with scanout, which always wins; we stall and retry.
module fb_draw_ctrl
    import chip8_pkg::*;
#(
    parameter bit          WRAP   = 1'b1,
    parameter int unsigned MEM_AW = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [5:0]        cmd_x,
    input  logic [4:0]        cmd_y,
    input  logic [3:0]        cmd_n,
    input  logic [MEM_AW-1:0] cmd_i,
    output logic              done,
    output logic              collision,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              disp_req,
    input  logic [7:0]        disp_addr,
    output logic [7:0]        fb_addr,
    output logic              fb_we,
    output logic [7:0]        fb_wdata,
    input  logic [7:0]        fb_rdata
);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        row_q, row_d;
    logic [5:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic [3:0]        n_q, n_d;
    logic [MEM_AW-1:0] i_q, i_d;
    logic [7:0]        spr_q, spr_d;
    logic [7:0]        old_q, old_d;
    logic              acc_q, acc_d;
    logic              collision_q, collision_d;

    logic [4:0] yr;
    logic [5:0] yr_next;
    logic [7:0] left_pat, right_pat, left_addr, right_addr;
    logic       right_valid;

    assign yr        = y_q + 5'(row_q);
    assign yr_next   = {1'b0, y_q} + {2'b00, row_q} + 6'd1;
    assign mem_addr  = i_q + MEM_AW'(row_q);
    assign collision = collision_q;

    sprite_align #(
        .WRAP(WRAP)
    ) u_align (
        .s          (spr_q),
        .x          (x_q),
        .yr         (yr),
        .left_pat   (left_pat),
        .right_pat  (right_pat),
        .left_addr  (left_addr),
        .right_addr (right_addr),
        .right_valid(right_valid)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        i_d         = i_q;
        spr_d       = spr_q;
        old_d       = old_q;
        acc_d       = acc_q;
        collision_d = collision_q;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        mem_rd      = 1'b0;
        fb_addr     = 8'h00;
        fb_we       = 1'b0;
        fb_wdata    = 8'h00;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    x_d   = cmd_x;
                    y_d   = cmd_y;
                    n_d   = cmd_n;
                    i_d   = cmd_i;
                    cnt_d = 8'h00;
                    row_d = 4'h0;
                    acc_d = 1'b0;
                    if (cmd_op_e'(cmd_op) == OP_CLS) begin
                        state_d = StClsWr;
                    end else if (cmd_n == 4'h0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StClsWr: begin
                if (!disp_req) begin
                    fb_we   = 1'b1;
                    fb_addr = cnt_q;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == 8'(FB_BYTES - 1)) state_d = StDone;
                end
            end
            StFetch: begin
                mem_rd  = 1'b1;
                state_d = StSprCap;
            end
            StSprCap: begin
                spr_d   = mem_rdata;
                state_d = StLRd;
            end
            StLRd: begin
                if (!disp_req) begin
                    fb_addr = left_addr;
                    state_d = StLCap;
                end
            end
            StLCap: begin
                old_d   = fb_rdata;
                acc_d   = acc_q | (|(fb_rdata & left_pat));
                state_d = StLWr;
            end
            StLWr: begin
                if (!disp_req) begin
                    fb_we    = 1'b1;
                    fb_addr  = left_addr;
                    fb_wdata = old_q ^ left_pat;
                    state_d  = right_valid ? StRRd : StNext;
                end
            end
            StRRd: begin
                if (!disp_req) begin
                    fb_addr = right_addr;
                    state_d = StRCap;
                end
            end
            StRCap: begin
                old_d   = fb_rdata;
                acc_d   = acc_q | (|(fb_rdata & right_pat));
                state_d = StRWr;
            end
            StRWr: begin
                if (!disp_req) begin
                    fb_we    = 1'b1;
                    fb_addr  = right_addr;
                    fb_wdata = old_q ^ right_pat;
                    state_d  = StNext;
                end
            end
            StNext: begin
                row_d = row_q + 4'd1;
                // Without wrap, the first row below the screen ends the sprite.
                if ((row_q + 4'd1) == n_q) begin
                    state_d = StDone;
                end else if (!WRAP && (yr_next >= 6'(FB_ROWS))) begin
                    state_d = StDone;
                end else begin
                    state_d = StFetch;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Publish VF on entry so it is already valid while done is high.
        if ((state_d == StDone) && (state_q != StDone)) collision_d = acc_d;

        if (disp_req) begin
            fb_addr  = disp_addr;
            fb_we    = 1'b0;
            fb_wdata = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= 8'h00;
            row_q       <= 4'h0;
            x_q         <= 6'h00;
            y_q         <= 5'h00;
            n_q         <= 4'h0;
            i_q         <= '0;
            spr_q       <= 8'h00;
            old_q       <= 8'h00;
            acc_q       <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            i_q         <= i_d;
            spr_q       <= spr_d;
            old_q       <= old_d;
            acc_q       <= acc_d;
            collision_q <= collision_d;
        end
    end

endmodule

// File: tb/tb_fb_draw_ctrl.sv
// Bench for fb_draw_ctrl: a WRAP=0 and a WRAP=1 instance run the same commands side by side
// against a pixel-level model of the 64x32 screen.
module tb_fb_draw_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_op = 1'b0;
    logic [5:0]  cmd_x = '0;
    logic [4:0]  cmd_y = '0;
    logic [3:0]  cmd_n = '0;
    logic [11:0] cmd_i = '0;
    logic        disp_req = 1'b0;
    logic [7:0]  disp_addr = '0;

    logic        cmd_ready [2];
    logic        done      [2];
    logic        collision [2];
    logic        mem_rd    [2];
    logic        fb_we     [2];
    logic [11:0] mem_addr  [2];
    logic [7:0]  mem_rdata [2];
    logic [7:0]  fb_addr   [2];
    logic [7:0]  fb_wdata  [2];
    logic [7:0]  fb_rdata  [2];

    logic [7:0]  sprite_mem [4096];
    logic [7:0]  fb_mem     [2][256];
    logic [7:0]  seed       [256];
    logic        load_req = 1'b0;

    bit          pix [2][32][64];
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    fb_draw_ctrl #(.WRAP(1'b0), .MEM_AW(12)) dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .done(done[0]), .collision(collision[0]), .mem_addr(mem_addr[0]),
        .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]), .disp_req(disp_req),
        .disp_addr(disp_addr), .fb_addr(fb_addr[0]), .fb_we(fb_we[0]),
        .fb_wdata(fb_wdata[0]), .fb_rdata(fb_rdata[0])
    );

    fb_draw_ctrl #(.WRAP(1'b1), .MEM_AW(12)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_i(cmd_i),
        .done(done[1]), .collision(collision[1]), .mem_addr(mem_addr[1]),
        .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]), .disp_req(disp_req),
        .disp_addr(disp_addr), .fb_addr(fb_addr[1]), .fb_we(fb_we[1]),
        .fb_wdata(fb_wdata[1]), .fb_rdata(fb_rdata[1])
    );

    // Sync framebuffer RAMs and sprite memory read ports, one per instance.
    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (load_req) begin
                for (int a = 0; a < 256; a++) fb_mem[w][a] <= seed[a];
            end else begin
                if (fb_we[w]) fb_mem[w][fb_addr[w]] <= fb_wdata[w];
                fb_rdata[w] <= fb_mem[w][fb_addr[w]];
            end
            if (mem_rd[w]) mem_rdata[w] <= sprite_mem[mem_addr[w]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_byte(int w, int a);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[7-b] = pix[w][a/8][(a%8)*8 + b];
        return v;
    endfunction

    task automatic model_clear(input int w, input int upto);
        for (int a = 0; a < upto; a++)
            for (int b = 0; b < 8; b++) pix[w][a/8][(a%8)*8 + b] = 1'b0;
    endtask

    // Screen-level XOR draw: wrap folds coordinates, clipping drops pixels/rows off-screen.
    task automatic model_drw(input int w, input int x, input int y, input int n, input int i,
                             output bit coll);
        coll = 1'b0;
        for (int r = 0; r < n; r++) begin
            int         py;
            logic [7:0] s;
            py = y + r;
            if (py >= 32) begin
                if (w == 0) break;
                py -= 32;
            end
            s = sprite_mem[(i + r) % 4096];
            for (int b = 0; b < 8; b++) begin
                int px;
                px = x + b;
                if (s[7-b]) begin
                    if (px >= 64 && w == 0) continue;
                    px = px % 64;
                    if (pix[w][py][px]) coll = 1'b1;
                    pix[w][py][px] = ~pix[w][py][px];
                end
            end
        end
    endtask

    // Edges from accept to done with a free port: 6 per aligned row, 9 per split row.
    function automatic int model_lat(int w, int x, int y, int n);
        int rows;
        bit split;
        if (n == 0) return 0;
        rows  = (w == 0 && y + n > 32) ? 32 - y : n;
        split = (x % 8 != 0) && (w == 1 || x < 56);
        return rows * (split ? 9 : 6);
    endfunction

    task automatic check_fb(input string tag);
        for (int w = 0; w < 2; w++) begin
            int bad;
            int first;
            bad   = 0;
            first = -1;
            for (int a = 0; a < 256; a++) begin
                if (fb_mem[w][a] !== model_byte(w, a)) begin
                    bad++;
                    if (first < 0) first = a;
                end
            end
            check($sformatf("%s_w%0d_fb_bad_bytes(first=%0d)", tag, w, first), bad, 0);
        end
    endtask

    task automatic seed_random();
        for (int a = 0; a < 256; a++) begin
            seed[a] = 8'($urandom);
            for (int w = 0; w < 2; w++)
                for (int b = 0; b < 8; b++) pix[w][a/8][(a%8)*8 + b] = seed[a][7-b];
        end
        load_req = 1'b1;
        @(posedge clk);
        #1 load_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!(cmd_ready[0] && cmd_ready[1]) && guard < 1000) begin
            @(posedge clk);
            #1 guard++;
        end
        check({tag, "_ready"}, {cmd_ready[1], cmd_ready[0]}, 2'b11);
    endtask

    // stall: 0 = port always free, 1 = random scanout, 2 = scanout window [hs, hs+hl).
    task automatic run_cmd(input string tag, input bit op, input int x, input int y,
                           input int n, input int i, input int stall, input int hs,
                           input int hl);
        bit exp_coll [2];
        int exp_lat  [2];
        int lat      [2];
        bit seen     [2];
        int e;
        for (int w = 0; w < 2; w++) begin
            if (!op) begin
                model_clear(w, 256);
                exp_coll[w] = 1'b0;
                exp_lat[w]  = 256;
            end else begin
                model_drw(w, x, y, n, i, exp_coll[w]);
                exp_lat[w] = model_lat(w, x, y, n) + ((stall == 2) ? hl : 0);
            end
            seen[w] = 1'b0;
            lat[w]  = -1;
        end
        wait_ready(tag);
        disp_req  = 1'b0;
        cmd_op    = op;
        cmd_x     = 6'(x);
        cmd_y     = 5'(y);
        cmd_n     = 4'(n);
        cmd_i     = 12'(i);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        // Scramble the command bus; the block must work from its own copy.
        cmd_op = 1'($urandom);
        cmd_x  = 6'($urandom);
        cmd_y  = 5'($urandom);
        cmd_n  = 4'($urandom);
        cmd_i  = 12'($urandom);
        e = 0;
        while (!(seen[0] && seen[1]) && e < 3000) begin
            for (int w = 0; w < 2; w++) begin
                if (!seen[w] && done[w]) begin
                    seen[w] = 1'b1;
                    lat[w]  = e;
                    check($sformatf("%s_w%0d_collision", tag, w), 32'(collision[w]),
                          32'(exp_coll[w]));
                end
            end
            if (stall == 1) begin
                disp_req  = ($urandom_range(0, 2) == 0);
                disp_addr = 8'($urandom);
            end else if (stall == 2) begin
                disp_req  = (e >= hs) && (e < hs + hl);
                disp_addr = 8'h33;
            end else begin
                disp_req = 1'b0;
            end
            #1;
            if (disp_req) begin
                for (int w = 0; w < 2; w++) begin
                    check($sformatf("%s_w%0d_we_under_disp", tag, w), 32'(fb_we[w]), 32'd0);
                    check($sformatf("%s_w%0d_addr_under_disp", tag, w), 32'(fb_addr[w]),
                          32'(disp_addr));
                end
            end
            @(posedge clk);
            #1 e++;
        end
        disp_req = 1'b0;
        for (int w = 0; w < 2; w++) begin
            check($sformatf("%s_w%0d_done_seen", tag, w), 32'(seen[w]), 32'd1);
            if (stall != 1) check($sformatf("%s_w%0d_latency", tag, w), lat[w], exp_lat[w]);
        end
        @(posedge clk);
        #1 check_fb(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int w = 0; w < 2; w++) begin
            check($sformatf("%s_w%0d_outs", tag, w),
                  {7'd0, cmd_ready[w], done[w], collision[w], mem_rd[w], fb_we[w],
                   fb_addr[w], fb_wdata[w]},
                  {7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) sprite_mem[a] = 8'($urandom);

        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        seed_random();
        run_cmd("cls_preloaded", 1'b0, 0, 0, 0, 0, 0, 0, 0);

        sprite_mem[12'h200] = 8'hF0;
        run_cmd("drw_f0", 1'b1, 0, 0, 1, 12'h200, 0, 0, 0);
        check("drw_f0_byte0", 32'(fb_mem[1][0]), 32'h0F0);
        run_cmd("drw_f0_again", 1'b1, 0, 0, 1, 12'h200, 0, 0, 0);
        check("drw_f0_again_byte0", 32'(fb_mem[1][0]), 32'h000);

        // Async reset in the middle of a CLS, with VF currently 1.
        seed_random();
        wait_ready("rst_cls");
        cmd_op    = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            check($sformatf("rst_cls_w%0d_counter", w), 32'(fb_addr[w]), 32'd100);
            check($sformatf("rst_cls_w%0d_we", w), 32'(fb_we[w]), 32'd1);
        end
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) model_clear(w, 100);
        check_fb("rst_partial");
        run_cmd("cls_after_reset", 1'b0, 0, 0, 0, 0, 0, 0, 0);

        sprite_mem[12'h210] = 8'hFF;
        run_cmd("drw_split", 1'b1, 3, 2, 1, 12'h210, 0, 0, 0);
        check("drw_split_byte16", 32'(fb_mem[1][16]), 32'h1F);
        check("drw_split_byte17", 32'(fb_mem[1][17]), 32'hE0);

        run_cmd("cls_edge", 1'b0, 0, 0, 0, 0, 0, 0, 0);
        sprite_mem[12'h300] = 8'hFF;
        sprite_mem[12'h301] = 8'hFF;
        run_cmd("edge", 1'b1, 60, 31, 2, 12'h300, 0, 0, 0);
        check("edge_w1_b255", 32'(fb_mem[1][255]), 32'h0F);
        check("edge_w1_b248", 32'(fb_mem[1][248]), 32'hF0);
        check("edge_w1_b7", 32'(fb_mem[1][7]), 32'h0F);
        check("edge_w1_b0", 32'(fb_mem[1][0]), 32'hF0);
        check("edge_w0_b255", 32'(fb_mem[0][255]), 32'h0F);
        check("edge_w0_b248", 32'(fb_mem[0][248]), 32'h00);
        check("edge_w0_b7", 32'(fb_mem[0][7]), 32'h00);
        check("edge_w0_b0", 32'(fb_mem[0][0]), 32'h00);

        // Scanout grabs the port for 10 cycles starting on the left-byte write cycle.
        sprite_mem[12'h400] = 8'hA5;
        run_cmd("disp_hold", 1'b1, 8, 5, 1, 12'h400, 2, 4, 10);
        check("disp_hold_byte41", 32'(fb_mem[1][41]), 32'hA5);

        run_cmd("drw_n0", 1'b1, 9, 9, 0, 12'h123, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int stall;
            stall = (k < 20) ? 0 : 1;
            if ($urandom_range(0, 7) == 0) begin
                run_cmd($sformatf("rand%0d_cls", k), 1'b0, 0, 0, 0, 0, stall, 0, 0);
            end else begin
                run_cmd($sformatf("rand%0d_drw", k), 1'b1, int'($urandom_range(0, 63)),
                        int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 4095)), stall, 0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
